// File: rtl/cios_word_sequencer.sv
// Sequencer for one outer CIOS iteration: walks the operand words through a single-word
// MAC cell, keeps the accumulator T, and folds the final carry into the top two words.
module cios_word_sequencer #(
    parameter int width  = 32,
    parameter int NWORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         clear,
    input  logic [width-1:0]             b_i,
    input  logic [NWORDS*width-1:0]      a_flat,
    output logic                         busy,
    output logic                         done,
    output logic [(NWORDS+2)*width-1:0]  t_flat,
    output logic                         mac_start,
    output logic [width-1:0]             mac_a,
    output logic [width-1:0]             mac_b,
    output logic [width-1:0]             mac_sin,
    output logic [width-1:0]             mac_cin,
    input  logic [width-1:0]             mac_sout,
    input  logic [width-1:0]             mac_cout,
    input  logic                         mac_done
);

    localparam int JW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    logic [JW-1:0]     j_r;
    logic [width-1:0]  c_r;
    logic [width-1:0]  b_r;
    logic [width-1:0]  a_r [NWORDS];
    logic [width-1:0]  t_r [NWORDS+2];
    logic              busy_r;
    logic              done_r;
    logic              mac_start_r;
    logic [width:0]    fold_s;

    // Final carry fold is a width+1 bit add so the carry-out lands in T[NWORDS+1].
    assign fold_s = {1'b0, t_r[NWORDS]} + {1'b0, c_r};

    assign busy      = busy_r;
    assign done      = done_r;
    assign mac_start = mac_start_r;
    assign mac_a     = a_r[j_r];
    assign mac_b     = b_r;
    assign mac_sin   = t_r[j_r];
    assign mac_cin   = c_r;

    for (genvar k = 0; k < NWORDS + 2; k++) begin : g_t
        assign t_flat[k*width +: width] = t_r[k];
    end

    // Iteration FSM with accumulator, carry, operand latches and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            j_r         <= '0;
            c_r         <= '0;
            b_r         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mac_start_r <= 1'b0;
            for (int k = 0; k < NWORDS; k++) a_r[k] <= '0;
            for (int k = 0; k < NWORDS + 2; k++) t_r[k] <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (clear) begin
                        for (int k = 0; k < NWORDS + 2; k++) t_r[k] <= '0;
                    end else if (start) begin
                        for (int k = 0; k < NWORDS; k++) a_r[k] <= a_flat[k*width +: width];
                        b_r         <= b_i;
                        j_r         <= '0;
                        c_r         <= '0;
                        busy_r      <= 1'b1;
                        mac_start_r <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mac_start_r <= 1'b0;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mac_done) begin
                        t_r[j_r] <= mac_sout;
                        c_r      <= mac_cout;
                        if (j_r == JW'(NWORDS - 1)) begin
                            state_r <= ST_FINAL;
                        end else begin
                            j_r         <= j_r + JW'(1);
                            mac_start_r <= 1'b1;
                            state_r     <= ST_ISSUE;
                        end
                    end
                end
                ST_FINAL: begin
                    t_r[NWORDS]   <= fold_s[width-1:0];
                    t_r[NWORDS+1] <= {{(width-1){1'b0}}, fold_s[width]};
                    done_r        <= 1'b1;
                    state_r       <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    mac_start_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cios_word_sequencer.sv
// Bench for cios_word_sequencer: vector table of whole iterations against a latency-
// programmable MAC model, scoreboard on done, plus hand sequences for reset/clear corners.
module tb_cios_word_sequencer;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TW = (N + 2) * W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            clear = 1'b0;
    logic [W-1:0]    b_i = '0;
    logic [N*W-1:0]  a_flat = '0;
    logic            busy, done, mac_start;
    logic [TW-1:0]   t_flat;
    logic [W-1:0]    mac_a, mac_b, mac_sin, mac_cin, mac_sout, mac_cout;
    logic            mac_done;

    cios_word_sequencer #(.width(W), .NWORDS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .b_i(b_i), .a_flat(a_flat),
        .busy(busy), .done(done), .t_flat(t_flat), .mac_start(mac_start),
        .mac_a(mac_a), .mac_b(mac_b), .mac_sin(mac_sin), .mac_cin(mac_cin),
        .mac_sout(mac_sout), .mac_cout(mac_cout), .mac_done(mac_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    function automatic void check(string name, logic [TW-1:0] got, logic [TW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // MAC model: result L cycles after the start is sampled; spurious pulses injectable.
    int           lat = 4;
    int           mcnt = 0;
    logic         mac_spur = 1'b0;
    logic [63:0]  mres = '0;
    logic [W-1:0] cap_a, cap_b, cap_s, cap_c;
    int           stab_bad = 0;

    always @(posedge clk) begin
        if (mac_start) begin
            mres  <= 64'(mac_a) * 64'(mac_b) + 64'(mac_sin) + 64'(mac_cin);
            mcnt  <= lat;
            cap_a <= mac_a; cap_b <= mac_b; cap_s <= mac_sin; cap_c <= mac_cin;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
        end
    end
    assign mac_sout = mres[31:0];
    assign mac_cout = mres[63:32];
    assign mac_done = (mcnt == 1) || mac_spur;

    always @(negedge clk) begin
        if (mcnt > 0 && busy &&
            (mac_a !== cap_a || mac_b !== cap_b || mac_sin !== cap_s || mac_cin !== cap_c))
            stab_bad++;
    end

    // Scoreboard: each done pulse consumes one expected accumulator value.
    logic [TW-1:0] sb_q [$];
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) check("unexpected_done", 1, 0);
            else check("t_result", t_flat, sb_q.pop_front());
        end
    end

    typedef struct {
        bit            do_rst;
        bit            do_clear;
        logic [N*W-1:0] a;
        logic [W-1:0]  b;
        int            l;
        bit            inject;
        logic [TW-1:0] exp_t;
        int            exp_cyc;
    } vec_t;

    vec_t vecs [7];

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic run_iter(input logic [N*W-1:0] a, input logic [W-1:0] b, input int l,
                            input bit inject, input logic [TW-1:0] exp_t, input int exp_cyc);
        int t0, k, got, ns, busy_bad;
        got = -1; ns = 0; busy_bad = 0;
        @(negedge clk);
        lat = l; stab_bad = 0;
        a_flat = a; b_i = b; start = 1'b1;
        sb_q.push_back(exp_t);
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            k = cyc - t0 + 1;
            if (mac_start) ns++;
            if (!busy) busy_bad++;
            mac_spur = inject && (k == 1);
            start    = inject && (k == 3 || done);
            clear    = inject && (k == 3 || done);
            if (inject && k == 3) a_flat = '1;
            if (done) begin
                got = k;
                break;
            end
        end
        check("done_cycle", got, exp_cyc);
        check("mac_start_count", ns, N);
        check("busy_cover", busy_bad, 0);
        check("operands_stable", stab_bad, 0);
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        check("idle_after_done", {busy, done}, 2'b00);
        check("sb_empty", sb_q.size(), 0);
    endtask

    localparam logic [N*W-1:0] A_ONE = {32'h1, 32'h1, 32'h1, 32'h1};
    localparam logic [N*W-1:0] A_MAX = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    localparam logic [TW-1:0]  T_ONE = {32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 32'h1};
    localparam logic [TW-1:0]  T_TWO = {32'h0, 32'h0, 32'h2, 32'h2, 32'h2, 32'h2};
    localparam logic [TW-1:0]  T_MAX = {32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'hFFFFFFFF, 32'h00000001};
    localparam logic [TW-1:0]  T_MX2 = {32'h1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'hFFFFFFFE, 32'h00000002};

    initial begin
        int t0;
        vecs[0] = '{1'b1, 1'b1, A_ONE, 32'h1,        4, 1'b0, T_ONE, 22};
        vecs[1] = '{1'b0, 1'b0, A_ONE, 32'h1,        4, 1'b0, T_TWO, 22};
        vecs[2] = '{1'b0, 1'b1, A_ONE, 32'h1,        4, 1'b1, T_ONE, 22};
        vecs[3] = '{1'b1, 1'b0, A_MAX, 32'hFFFFFFFF, 4, 1'b0, T_MAX, 22};
        vecs[4] = '{1'b0, 1'b0, A_MAX, 32'hFFFFFFFF, 4, 1'b0, T_MX2, 22};
        vecs[5] = '{1'b0, 1'b1, A_MAX, 32'hFFFFFFFF, 1, 1'b0, T_MAX, 10};
        vecs[6] = '{1'b0, 1'b1, A_MAX, 32'hFFFFFFFF, 7, 1'b0, T_MAX, 34};

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, mac_start}, 3'b000);
        check("reset_t", t_flat, '0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_rst) do_reset();
            if (vecs[i].do_clear) do_clear();
            run_iter(vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].inject,
                     vecs[i].exp_t, vecs[i].exp_cyc);
        end

        // Spurious mac_done in IDLE must not touch T.
        @(negedge clk); mac_spur = 1'b1;
        @(negedge clk); mac_spur = 1'b0;
        check("idle_spur_t", t_flat, T_MAX);
        check("idle_spur_busy", busy, 1'b0);

        // Clear in IDLE zeroes T without a done pulse (monitor flags any done).
        do_clear();
        check("clear_t", t_flat, '0);
        check("clear_no_done", {busy, done}, 2'b00);

        // Reset mid-iteration, then a late mac_done, then a fresh iteration.
        @(negedge clk);
        lat = 4; a_flat = A_MAX; b_i = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        while (cyc - t0 + 1 < 10) @(negedge clk);
        check("mid_t0", t_flat[31:0], 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_t", t_flat, '0);
        mac_spur = 1'b1;
        @(negedge clk);
        mac_spur = 1'b0;
        check("late_done_ignored", {busy, done, mac_start}, 3'b000);
        check("late_done_t", t_flat, '0);
        run_iter(A_MAX, 32'hFFFFFFFF, 4, 1'b0, T_MAX, 22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
